readout_capture: RTL

- Receive side of the 4-pixel camera readout protocol.
- Watches the nre1/nre2/adc strobes driven by the readout sequencer and samples the two column ADC outputs on each adc rising edge.
- Assembles a 2x2 frame and delivers it downstream over a valid/ready handshake.
- Sits between the pixel array/column ADCs and the frame consumer.

---
 rtl/readout_capture.sv | 121 ++++++++++++
 1 files changed

// File: rtl/readout_capture.sv
// Receive side of the 4-pixel camera readout: detects adc strobes, captures two rows, hands a 2x2 frame downstream.
// Optional pix_sum output is enabled with `define READOUT_CAPTURE_SUM_EN.
module readout_capture #(
  parameter int ADC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nre1,
  input  logic               nre2,
  input  logic               adc,
  input  logic [2*ADC_W-1:0] col_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ADC_W-1:0] pix,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               proto_err,
`ifdef READOUT_CAPTURE_SUM_EN
  output logic [ADC_W+1:0]   pix_sum,
`endif
  output logic               overrun
);

  typedef enum logic {
    WAIT_R1,
    WAIT_R2
  } state_t;

  state_t             state;
  logic               adc_q;
  logic [2*ADC_W-1:0] row1_buf;

  logic               cap;
  logic               sel_row1;
  logic               sel_row2;
  logic               frame_done;
  logic               transfer;
  logic               can_load;
  logic [4*ADC_W-1:0] frame_next;

  assign cap        = adc & ~adc_q;
  assign sel_row1   = nre1 & ~nre2;
  assign sel_row2   = ~nre1 & nre2;
  assign frame_done = cap & sel_row2 & (state == WAIT_R2);
  assign transfer   = out_valid & out_ready;
  // A frame may load when the output slot is empty or is being emptied on this very edge.
  assign can_load   = ~out_valid | out_ready;
  assign frame_next = {col_data, row1_buf};

`ifdef READOUT_CAPTURE_SUM_EN
  logic [ADC_W+1:0] sum_next;

  always_comb begin
    sum_next = {2'b00, frame_next[0*ADC_W +: ADC_W]}
             + {2'b00, frame_next[1*ADC_W +: ADC_W]}
             + {2'b00, frame_next[2*ADC_W +: ADC_W]}
             + {2'b00, frame_next[3*ADC_W +: ADC_W]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_sum <= '0;
    end else if (frame_done && can_load) begin
      pix_sum <= sum_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_R1;
      adc_q     <= 1'b0;
      row1_buf  <= '0;
      out_valid <= 1'b0;
      pix       <= '0;
      frame_cnt <= '0;
      proto_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      adc_q <= adc;

      if (transfer) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        out_valid <= 1'b0;
      end

      if (cap) begin
        if (!sel_row1 && !sel_row2) begin
          proto_err <= 1'b1;
        end else begin
          unique case (state)
            WAIT_R1: begin
              if (sel_row1) begin
                row1_buf <= col_data;
                state    <= WAIT_R2;
              end else begin
                proto_err <= 1'b1;
              end
            end
            WAIT_R2: begin
              // A repeated row1 means the sequencer restarted; keep the newest row1.
              if (sel_row1) begin
                row1_buf <= col_data;
              end else begin
                state <= WAIT_R1;
                if (can_load) begin
                  pix       <= frame_next;
                  out_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
            default: state <= WAIT_R1;
          endcase
        end
      end
    end
  end

endmodule
